prbs_gen_chk: RTL and testbench

Parallel PRBS generator and self-synchronising checker for the CSI RX testbench and link bring-up paths. Produces DW pattern bits per clock from a selectable ITU polynomial and checks a returned DW-bit stream against the same polynomial. The checker has a lock state machine and a saturating error counter. It generalises the single-bit, load/enable LFSR with multi-bit-per-cycle operation, error injection, and checking.

---
 rtl/prbs_gen_chk.sv | 133 +++++++++++++
 tb/tb_prbs_gen_chk.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: parallel PRBS generator and self-synchronising checker with lock FSM and saturating error counter
module prbs_gen_chk #(
    parameter int PRBS     = 7,
    parameter int DW       = 8,
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic             i_sysclk,
    input  logic             i_areset,
    input  logic             i_gen_load,
    input  logic [PRBS-1:0]  i_gen_seed,
    input  logic             i_gen_en,
    input  logic             i_inject_err,
    output logic [DW-1:0]    o_gen_data,
    output logic             o_gen_valid,
    input  logic             i_chk_valid,
    input  logic [DW-1:0]    i_chk_data,
    input  logic             i_chk_clr,
    output logic             o_chk_locked,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_err_flag
);
    localparam bit LEGAL = (PRBS == 7 || PRBS == 9 || PRBS == 15 || PRBS == 23 || PRBS == 31) && DW >= 1 && DW <= 64;
    localparam int TAP = PRBS == 7 ? 6 : PRBS == 9 ? 5 : PRBS == 15 ? 14 : PRBS == 23 ? 18 : PRBS == 31 ? 28 : 1;
    localparam int PW = $clog2(DW + 1);
    localparam int SW = (ERR_W > PW ? ERR_W : PW) + 1;
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic SEARCH = 1'b0;
    localparam logic LOCKED = 1'b1;

    if (!LEGAL) begin : g_bad_param
        $error("prbs_gen_chk: unsupported PRBS order or DW");
    end

    logic [PRBS-1:0] gen_state, gen_next, hist, hist_next;
    logic [DW-1:0]   gen_word, e_comb, e_r;
    logic [PW-1:0]   pop;
    logic [SW-1:0]   cnt_sum;
    logic [RW-1:0]   run;
    logic [LW-1:0]   loss;
    logic            v_r, state, err;

    always_comb begin
        gen_next = gen_state;
        gen_word = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            gen_word[i] = gen_next[PRBS-1] ^ gen_next[TAP-1];
            gen_next = {gen_next[PRBS-2:0], gen_word[i]};
        end
    end

    always_ff @(posedge i_sysclk or posedge i_areset) begin
        if (i_areset) begin
            gen_state   <= '1;
            o_gen_data  <= '0;
            o_gen_valid <= 1'b0;
        end else if (i_gen_load) begin
            gen_state   <= (i_gen_seed == '0) ? '1 : i_gen_seed;
            o_gen_valid <= 1'b0;
        end else begin
            o_gen_valid <= i_gen_en;
            if (i_gen_en) begin
                gen_state  <= gen_next;
                o_gen_data <= gen_word ^ DW'(i_inject_err);
            end
        end
    end

    // history bits carry across the word boundary so every bit is checked against the true stream
    always_comb begin
        hist_next = hist;
        e_comb = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            e_comb[i] = i_chk_data[i] ^ hist_next[PRBS-1] ^ hist_next[TAP-1];
            hist_next = {hist_next[PRBS-2:0], i_chk_data[i]};
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < DW; i++) pop = pop + PW'(e_r[i]);
    end

    assign err = pop != '0;
    assign cnt_sum = (i_chk_clr ? SW'(0) : SW'(o_err_cnt)) + ((v_r && state == LOCKED) ? SW'(pop) : SW'(0));
    assign o_chk_locked = state;

    always_ff @(posedge i_sysclk or posedge i_areset) begin
        if (i_areset) begin
            hist <= '0;
            e_r  <= '0;
            v_r  <= 1'b0;
        end else begin
            v_r <= i_chk_valid;
            if (i_chk_valid) begin
                hist <= hist_next;
                e_r  <= e_comb;
            end
        end
    end

    always_ff @(posedge i_sysclk or posedge i_areset) begin
        if (i_areset) begin
            state      <= SEARCH;
            run        <= '0;
            loss       <= '0;
            o_err_cnt  <= '0;
            o_err_flag <= 1'b0;
        end else begin
            o_err_cnt <= |cnt_sum[SW-1:ERR_W] ? '1 : cnt_sum[ERR_W-1:0];
            if (v_r) begin
                o_err_flag <= err;
                if (state == SEARCH) begin
                    loss <= '0;
                    if (err) run <= '0;
                    else if (run == RW'(LOCK_CNT - 1)) begin
                        run   <= '0;
                        state <= LOCKED;
                    end else run <= run + 1'b1;
                end else begin
                    run <= '0;
                    if (!err) loss <= '0;
                    else if (loss == LW'(LOSS_CNT - 1)) begin
                        loss  <= '0;
                        state <= SEARCH;
                    end else loss <= loss + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed checks of generator words, checker lock/loss, error counting, saturation and async reset
module tb_prbs_gen_chk;
    logic clk = 1'b0, rst = 1'b1;
    logic gen_load = 1'b0, gen_en = 1'b0, inj = 1'b0, clr = 1'b0, lb = 1'b1, tb_valid = 1'b0;
    logic [6:0] seed = '0;
    logic [7:0] tb_data = '0;
    logic [7:0] gen_data_a, gen_data_b, chk_data_a, chk_data_b;
    logic gen_valid_a, gen_valid_b, chk_valid_a, chk_valid_b;
    logic locked_a, locked_b, flag_a, flag_b;
    logic [15:0] cnt_a;
    logic [3:0] cnt_b;
    int total = 0, bad = 0;

    typedef struct {
        logic load;
        logic [6:0] seed;
        logic en;
        logic inj;
        logic [7:0] data;
        logic valid;
    } vec_t;
    vec_t vt [11];

    always #5 clk = ~clk;

    assign chk_valid_a = lb ? gen_valid_a : tb_valid;
    assign chk_data_a  = lb ? gen_data_a : tb_data;
    assign chk_valid_b = lb ? gen_valid_b : tb_valid;
    assign chk_data_b  = lb ? gen_data_b : tb_data;

    prbs_gen_chk u_a (
        .i_sysclk(clk), .i_areset(rst), .i_gen_load(gen_load), .i_gen_seed(seed), .i_gen_en(gen_en),
        .i_inject_err(inj), .o_gen_data(gen_data_a), .o_gen_valid(gen_valid_a), .i_chk_valid(chk_valid_a),
        .i_chk_data(chk_data_a), .i_chk_clr(clr), .o_chk_locked(locked_a), .o_err_cnt(cnt_a), .o_err_flag(flag_a)
    );

    prbs_gen_chk #(.ERR_W(4)) u_b (
        .i_sysclk(clk), .i_areset(rst), .i_gen_load(gen_load), .i_gen_seed(seed), .i_gen_en(gen_en),
        .i_inject_err(inj), .o_gen_data(gen_data_b), .o_gen_valid(gen_valid_b), .i_chk_valid(chk_valid_b),
        .i_chk_data(chk_data_b), .i_chk_clr(clr), .o_chk_locked(locked_b), .o_err_cnt(cnt_b), .o_err_flag(flag_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic i, input logic c);
        inj = i;
        clr = c;
        @(posedge clk);
        #1;
        inj = 1'b0;
        clr = 1'b0;
    endtask

    logic mq[$];
    logic nb;
    logic [7:0] w;
    logic [7:0] words [254];
    int pm, rp, nerr, e;

    initial begin
        vt[0]  = '{1'b0, 7'h00, 1'b1, 1'b0, 8'h02, 1'b1};
        vt[1]  = '{1'b0, 7'h00, 1'b1, 1'b0, 8'h0C, 1'b1};
        vt[2]  = '{1'b0, 7'h00, 1'b0, 1'b0, 8'h0C, 1'b0};
        vt[3]  = '{1'b0, 7'h00, 1'b1, 1'b1, 8'h29, 1'b1};
        vt[4]  = '{1'b0, 7'h00, 1'b1, 1'b0, 8'hF2, 1'b1};
        vt[5]  = '{1'b1, 7'h00, 1'b1, 1'b0, 8'hF2, 1'b0};
        vt[6]  = '{1'b0, 7'h00, 1'b1, 1'b0, 8'h02, 1'b1};
        vt[7]  = '{1'b1, 7'h01, 1'b0, 1'b0, 8'h02, 1'b0};
        vt[8]  = '{1'b0, 7'h00, 1'b1, 1'b0, 8'h06, 1'b1};
        vt[9]  = '{1'b1, 7'h7F, 1'b0, 1'b0, 8'h06, 1'b0};
        vt[10] = '{1'b0, 7'h00, 1'b1, 1'b0, 8'h02, 1'b1};

        #12;
        check("reset gen_data", 32'(gen_data_a), 0);
        check("reset gen_valid", 32'(gen_valid_a), 0);
        check("reset locked", 32'(locked_a), 0);
        check("reset err_cnt", 32'(cnt_a), 0);
        check("reset err_flag", 32'(flag_a), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            gen_load = vt[k].load;
            seed = vt[k].seed;
            gen_en = vt[k].en;
            inj = vt[k].inj;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d gen_data", k), 32'(gen_data_a), 32'(vt[k].data));
            check($sformatf("vec%0d gen_valid", k), 32'(gen_valid_a), 32'(vt[k].valid));
        end
        check("vec gen_data inst b", 32'(gen_data_b), 32'h02);
        inj = 1'b0;

        gen_load = 1'b1;
        seed = 7'h7F;
        gen_en = 1'b0;
        step(0, 0);
        gen_load = 1'b0;
        gen_en = 1'b1;
        for (int k = 0; k < 7; k++) mq.push_back(1'b1);
        pm = 0;
        for (int k = 0; k < 254; k++) begin
            for (int j = 7; j >= 0; j--) begin
                nb = mq[mq.size() - 7] ^ mq[mq.size() - 6];
                mq.push_back(nb);
                w[j] = nb;
            end
            step(0, 0);
            words[k] = gen_data_a;
            if (gen_data_a !== w) pm++;
        end
        rp = 0;
        for (int k = 0; k < 127; k++) if (words[k] !== words[k + 127]) rp++;
        check("period model mismatches", 32'(pm), 0);
        check("period repeat mismatches", 32'(rp), 0);

        gen_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gen_en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(0, 0);
            if (k == 3) check("first word errored", 32'(flag_a), 1);
            if (k == 4) check("second word clean", 32'(flag_a), 0);
            if (k == 10) check("not yet locked", 32'(locked_a), 0);
            if (k == 11) begin
                check("locked", 32'(locked_a), 1);
                check("locked inst b", 32'(locked_b), 1);
                check("no count before lock", 32'(cnt_a), 0);
            end
        end

        nerr = 0;
        for (int k = 0; k < 10000; k++) begin
            step(0, 0);
            if (cnt_a !== 0 || locked_a !== 1'b1 || flag_a !== 1'b0) nerr++;
        end
        check("long loopback clean cycles", 32'(nerr), 0);

        step(1, 0);
        step(0, 0);
        check("inject flag before", 32'(flag_a), 0);
        step(0, 0);
        check("inject flag word1", 32'(flag_a), 1);
        check("inject cnt word1", 32'(cnt_a), 1);
        step(0, 0);
        check("inject flag word2", 32'(flag_a), 1);
        check("inject cnt", 32'(cnt_a), 3);
        step(0, 0);
        check("inject flag after", 32'(flag_a), 0);
        check("inject still locked", 32'(locked_a), 1);

        for (int b = 0; b < 3; b++) begin
            step(1, 0);
            step(1, 0);
            repeat (6) step(0, 0);
            e = 3 + 6 * (b + 1);
            check($sformatf("burst%0d cnt a", b), 32'(cnt_a), e);
            check($sformatf("burst%0d cnt b sat", b), 32'(cnt_b), e > 15 ? 15 : e);
            check($sformatf("burst%0d locked b", b), 32'(locked_b), 1);
        end

        step(1, 0);
        step(0, 0);
        step(0, 1);
        check("clr+err cnt a", 32'(cnt_a), 1);
        check("clr+err cnt b", 32'(cnt_b), 1);
        step(0, 0);
        check("after clr cnt a", 32'(cnt_a), 3);
        check("after clr cnt b", 32'(cnt_b), 3);

        lb = 1'b0;
        tb_valid = 1'b1;
        tb_data = 8'h00;
        repeat (4) step(0, 0);
        step(0, 1);
        tb_valid = 1'b0;
        tb_data = 8'hAA;
        repeat (3) step(0, 0);
        tb_valid = 1'b1;
        tb_data = 8'h00;
        repeat (3) step(0, 0);
        check("zero words cnt", 32'(cnt_a), 0);
        check("zero words locked", 32'(locked_a), 1);
        check("zero words flag", 32'(flag_b), 0);

        for (int k = 0; k < 10; k++) begin
            tb_data = (k % 2 == 0) ? 8'hAA : 8'h55;
            step(0, 0);
            if (k == 3) begin
                check("alt 3 words cnt", 32'(cnt_a), 12);
                check("alt 3 words locked", 32'(locked_a), 1);
            end
            if (k == 4) begin
                check("alt loss cnt", 32'(cnt_a), 15);
                check("alt loss unlocked", 32'(locked_a), 0);
            end
        end
        check("alt frozen cnt a", 32'(cnt_a), 15);
        check("alt frozen cnt b", 32'(cnt_b), 15);
        check("alt unlocked", 32'(locked_a), 0);
        check("alt flag", 32'(flag_a), 1);

        #2;
        rst = 1'b1;
        gen_load = 1'b1;
        seed = 7'h00;
        gen_en = 1'b0;
        #1;
        check("async gen_data", 32'(gen_data_a), 0);
        check("async gen_valid", 32'(gen_valid_a), 0);
        check("async locked", 32'(locked_a), 0);
        check("async cnt a", 32'(cnt_a), 0);
        check("async cnt b", 32'(cnt_b), 0);
        check("async flag", 32'(flag_a), 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0);
        check("seed0 load valid", 32'(gen_valid_a), 0);
        gen_load = 1'b0;
        gen_en = 1'b1;
        step(0, 0);
        check("seed0 first word", 32'(gen_data_a), 32'h02);
        check("seed0 first valid", 32'(gen_valid_a), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
